// File: rtl/inst_fetcher.sv
// inst_fetcher: fetch PC holder, direct-mapped one-word-per-line icache, next-PC predictor and queue pusher.
// Optional feature macro: IF_BHT_EN (2-bit saturating branch history table; branches predicted not taken without it).
// Ports:
//   clk, rst (async active-high), rdy (global enable, low freezes all state)
//   IQ_is_full                      : queue cannot accept an entry this cycle
//   IF_output_valid/IF_inst/IF_inst_pc/IF_predicted_to_jump/IF_predicted_pc : registered queue push
//   MC_request_valid/MC_addr        : miss request, held until MC_inst_valid
//   MC_inst_valid/MC_inst           : one-cycle memory response
//   ROB_roll_back_flag/ROB_target_pc: mispredict redirect
//   ROB_br_valid/ROB_br_pc/ROB_br_taken : committed branch outcome for the BHT
module inst_fetcher #(
    parameter int          ICACHE_IDX_W = 6,
    parameter int          BHT_IDX_W    = 6,
    parameter logic [31:0] RESET_PC     = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        IQ_is_full,
    output logic        IF_output_valid,
    output logic [31:0] IF_inst,
    output logic [31:0] IF_inst_pc,
    output logic        IF_predicted_to_jump,
    output logic [31:0] IF_predicted_pc,
    output logic        MC_request_valid,
    output logic [31:0] MC_addr,
    input  logic        MC_inst_valid,
    input  logic [31:0] MC_inst,
    input  logic        ROB_roll_back_flag,
    input  logic [31:0] ROB_target_pc,
    input  logic        ROB_br_valid,
    input  logic [31:0] ROB_br_pc,
    input  logic        ROB_br_taken
);
    localparam int LINES = 1 << ICACHE_IDX_W;
    localparam int TAG_W = 30 - ICACHE_IDX_W;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BR  = 7'b1100011;

    typedef enum logic [1:0] {IDLE, WAIT_MEM, FLUSH} state_t;

    state_t            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic              ov_q, ov_d, jump_q, jump_d, req_q, req_d;
    logic [31:0]       inst_q, inst_d, ipc_q, ipc_d, ppc_q, ppc_d, addr_q, addr_d;
    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q [LINES];
    logic [31:0]       data_q [LINES];

    logic [ICACHE_IDX_W-1:0] idx, fidx;
    logic [31:0]       word, j_imm, b_imm, pred_pc;
    logic              hit, br_taken, pred_jump, fill, unused_br;

    assign idx       = pc_q[ICACHE_IDX_W+1:2];
    assign fidx      = addr_q[ICACHE_IDX_W+1:2];
    assign word      = data_q[idx];
    assign hit       = valid_q[idx] && tag_q[idx] == pc_q[31:ICACHE_IDX_W+2];
    assign j_imm     = {{12{word[31]}}, word[19:12], word[20], word[30:21], 1'b0};
    assign b_imm     = {{20{word[31]}}, word[7], word[30:25], word[11:8], 1'b0};
    assign pred_jump = word[6:0] == OP_JAL || (word[6:0] == OP_BR && br_taken);
    assign pred_pc   = pc_q + (word[6:0] == OP_JAL ? j_imm : pred_jump ? b_imm : 32'd4);
    // A request is outstanding in every non-IDLE state, so any response there completes it.
    assign fill      = state_q != IDLE && MC_inst_valid;
    assign unused_br = ^{ROB_br_valid, ROB_br_pc, ROB_br_taken};

    assign IF_output_valid      = ov_q;
    assign IF_inst              = inst_q;
    assign IF_inst_pc           = ipc_q;
    assign IF_predicted_to_jump = jump_q;
    assign IF_predicted_pc      = ppc_q;
    assign MC_request_valid     = req_q;
    assign MC_addr              = addr_q;

`ifdef IF_BHT_EN
    logic [1:0]           bht_q [1 << BHT_IDX_W];
    logic [BHT_IDX_W-1:0] upd_idx;
    assign upd_idx  = ROB_br_pc[BHT_IDX_W+1:2];
    assign br_taken = bht_q[pc_q[BHT_IDX_W+1:2]][1];
    always_ff @(posedge clk or posedge rst)
        if (rst)
            for (int i = 0; i < (1 << BHT_IDX_W); i++) bht_q[i] <= 2'b01;
        else if (rdy && ROB_br_valid)
            bht_q[upd_idx] <= ROB_br_taken ? (bht_q[upd_idx] == 2'b11 ? 2'b11 : bht_q[upd_idx] + 2'd1)
                                           : (bht_q[upd_idx] == 2'b00 ? 2'b00 : bht_q[upd_idx] - 2'd1);
`else
    assign br_taken = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ov_d    = 1'b0;
        inst_d  = inst_q;
        ipc_d   = ipc_q;
        jump_d  = jump_q;
        ppc_d   = ppc_q;
        req_d   = req_q;
        addr_d  = addr_q;
        if (fill) begin
            req_d   = 1'b0;
            state_d = IDLE;
        end
        if (ROB_roll_back_flag) begin
            pc_d = ROB_target_pc;
            // Keep waiting for the in-flight word so it is absorbed instead of pushed.
            if (state_q != IDLE && !MC_inst_valid) state_d = FLUSH;
        end else if (state_q == IDLE) begin
            if (!hit) begin
                req_d   = 1'b1;
                addr_d  = {pc_q[31:2], 2'b00};
                state_d = WAIT_MEM;
            end else if (!IQ_is_full) begin
                ov_d   = 1'b1;
                inst_d = word;
                ipc_d  = pc_q;
                jump_d = pred_jump;
                ppc_d  = pred_pc;
                pc_d   = pred_pc;
            end
        end
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            ov_q    <= 1'b0;
            inst_q  <= '0;
            ipc_q   <= '0;
            jump_q  <= 1'b0;
            ppc_q   <= '0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            valid_q <= '0;
        end else if (rdy) begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ov_q    <= ov_d;
            inst_q  <= inst_d;
            ipc_q   <= ipc_d;
            jump_q  <= jump_d;
            ppc_q   <= ppc_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            if (fill) valid_q[fidx] <= 1'b1;
        end

    always_ff @(posedge clk)
        if (rdy && fill) begin
            tag_q[fidx]  <= addr_q[31:ICACHE_IDX_W+2];
            data_q[fidx] <= MC_inst;
        end
endmodule
